// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns valid/ready commands into APB SETUP+ACCESS transfers.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES waits.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t                r_state, w_state;
  logic                  r_psel, w_psel;
  logic                  r_penable, w_penable;
  logic                  r_pwrite, w_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr, w_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata;
  logic [STRB_WIDTH-1:0] r_pstrb, w_pstrb;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata;
  logic                  r_rsp_err, w_rsp_err;
  logic                  w_accept;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_rsp_to, w_rsp_to;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES > 0);
`endif

  assign cmd_ready = (r_state == S_IDLE) && !preset;
  assign w_accept  = cmd_valid && cmd_ready;

  always_comb begin
    w_state     = r_state;
    w_psel      = r_psel;
    w_penable   = r_penable;
    w_pwrite    = r_pwrite;
    w_paddr     = r_paddr;
    w_pwdata    = r_pwdata;
    w_pstrb     = r_pstrb;
    w_rsp_valid = r_rsp_valid;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_err   = r_rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
    w_cnt       = r_cnt;
    w_rsp_to    = r_rsp_to;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_paddr   = cmd_addr;
          w_pwrite  = cmd_write;
          w_pwdata  = cmd_wdata;
          w_pstrb   = cmd_write ? cmd_strb : '0;
          w_psel    = 1'b1;
          w_penable = 1'b0;
          w_state   = S_SETUP;
        end
      end
      S_SETUP: begin
        w_penable = 1'b1;
        w_state   = S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        w_cnt     = '0;
`endif
      end
      S_ACCESS: begin
        if (pready) begin
          w_rsp_rdata = r_pwrite ? '0 : prdata;
          w_rsp_err   = pslverr;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_state     = S_RESP;
`ifdef APB_MASTER_TIMEOUT_EN
          w_rsp_to    = 1'b0;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          // last allowed wait cycle elapsed with no pready: abort
          w_rsp_rdata = '1;
          w_rsp_err   = 1'b1;
          w_rsp_to    = 1'b1;
          w_psel      = 1'b0;
          w_penable   = 1'b0;
          w_rsp_valid = 1'b1;
          w_state     = S_RESP;
        end else begin
          w_cnt = r_cnt + 1'b1;
`endif
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_state     = S_IDLE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= S_IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      r_cnt       <= '0;
      r_rsp_to    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_pstrb     <= w_pstrb;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_err   <= w_rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
      r_cnt       <= w_cnt;
      r_rsp_to    <= w_rsp_to;
`endif
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = r_rsp_to;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed APB master bench with response scoreboard.
// Timeout test runs only when APB_MASTER_TIMEOUT_EN is defined.
module tb_apb_cmd_master;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [7:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  apb_cmd_master dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_pop  = 0;
  int   n_push = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: pops on every response handshake
  always @(negedge pclk) begin
    if (!preset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        n_pop++;
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
      end
    end
  end

  always @(negedge pclk) begin
    if (penable) chk("penable_wo_psel", {31'd0, psel}, 32'd1);
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_access(input logic w, input logic [7:0] a,
                            input logic [31:0] wd, input logic [3:0] st);
    chk("acc_psel", {31'd0, psel}, 32'd1);
    chk("acc_penable", {31'd0, penable}, 32'd1);
    chk("acc_paddr", {24'd0, paddr}, {24'd0, a});
    chk("acc_pwrite", {31'd0, pwrite}, {31'd0, w});
    chk("acc_pwdata", pwdata, wd);
    chk("acc_pstrb", {28'd0, pstrb}, {28'd0, (w ? st : 4'h0)});
    chk("acc_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic start_cmd(input logic w, input logic [7:0] a,
                           input logic [31:0] wd, input logic [3:0] st);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_strb  = st;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
    chk("setup_psel", {31'd0, psel}, 32'd1);
    chk("setup_penable", {31'd0, penable}, 32'd0);
    chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk_access(w, a, wd, st);
  endtask

  task automatic do_cmd(input logic w, input logic [7:0] a,
                        input logic [31:0] wd, input logic [3:0] st,
                        input int waits, input logic [31:0] prd,
                        input logic slv, input logic wait_err,
                        input int d);
    rsp_t e;
    e.rdata = w ? 32'h0 : prd;
    e.err   = slv;
    e.to    = 1'b0;
    sb.push_back(e);
    n_push++;
    start_cmd(w, a, wd, st);
    for (int i = 0; i < waits; i++) begin
      pready    = 1'b0;
      pslverr   = wait_err;
      prdata    = 32'h5A5A_0000 + 32'(i);
      cmd_valid = 1'b1;
      cmd_addr  = 8'h77;
      cmd_wdata = 32'h1111_2222;
      tick();
      chk_access(w, a, wd, st);
    end
    cmd_valid = 1'b0;
    pready    = 1'b1;
    pslverr   = slv;
    prdata    = w ? 32'h5555_AAAA : prd;
    rsp_ready = (d == 0);
    tick();
    pready  = 1'b0;
    pslverr = 1'b0;
    chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("done_psel", {31'd0, psel}, 32'd0);
    chk("done_penable", {31'd0, penable}, 32'd0);
    for (int i = 0; i < d; i++) begin
      tick();
      chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, e.rdata);
      chk("hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("hold_psel", {31'd0, psel}, 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("back_idle", {31'd0, cmd_ready}, 32'd1);
    chk("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    preset    = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h0;
    cmd_wdata = 32'h0;
    cmd_strb  = 4'h0;
    rsp_ready = 1'b0;
    prdata    = 32'h0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    tick();
    tick();
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_psel", {31'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_paddr", {24'd0, paddr}, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    preset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

    do_cmd(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 1'b0, 0);
    do_cmd(1'b0, 8'h04, 32'h0, 4'hF, 0, 32'h12345678, 1'b0, 1'b0, 0);
    do_cmd(1'b0, 8'hFF, 32'h0, 4'h0, 0, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
    do_cmd(1'b1, 8'h10, 32'hA5A50001, 4'h3, 3, 32'h0, 1'b0, 1'b1, 0);
    do_cmd(1'b0, 8'h20, 32'h0, 4'hC, 2, 32'hCAFEF00D, 1'b0, 1'b1, 5);
    do_cmd(1'b1, 8'h08, 32'h00C0FFEE, 4'h1, 1, 32'h0, 1'b1, 1'b0, 2);

    start_cmd(1'b0, 8'h30, 32'h0, 4'h0);
    pready = 1'b0;
    tick();
    preset = 1'b1;
    tick();
    chk("mid_rst_psel", {31'd0, psel}, 32'd0);
    chk("mid_rst_penable", {31'd0, penable}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    preset = 1'b0;
    #1;
    chk("after_rst_ready", {31'd0, cmd_ready}, 32'd1);

    do_cmd(1'b0, 8'h44, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0, 1'b0, 0);

`ifdef APB_MASTER_TIMEOUT_EN
    begin
      rsp_t e;
      int   n;
      e.rdata = 32'hFFFFFFFF;
      e.err   = 1'b1;
      e.to    = 1'b1;
      sb.push_back(e);
      n_push++;
      start_cmd(1'b1, 8'h50, 32'h12340000, 4'hF);
      pready = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin
        tick();
        n++;
      end
      chk("to_wait_cycles", 32'(n), 32'd16);
      chk("to_psel", {31'd0, psel}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("to_back_idle", {31'd0, cmd_ready}, 32'd1);
    end
`endif

    tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("sb_pop_count", 32'(n_pop), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Upstream requester stage for the APB slave.
- Accepts simple commands on a valid/ready interface and turns each into one APB SETUP+ACCESS transfer on the slave's bus, with PREADY wait-state support.
- Returns read data and error status on a valid/ready response interface.
- Serves as the protocol-correct driver that the slave's APB compliance checks sit on.

Parameters:
ADDR_WIDTH, 8, width of cmd_addr/paddr
DATA_WIDTH, 32, width of write/read data
STRB_WIDTH, DATA_WIDTH/8, byte-strobe width
TIMEOUT_CYCLES, 16, max ACCESS cycles with pready low before abort (used only with APB_MASTER_TIMEOUT_EN)

Ports:
pclk  input  1  clock; all logic on rising edge
preset  input  1  reset, synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_WIDTH  target address
cmd_wdata  input  DATA_WIDTH  write data
cmd_strb  input  STRB_WIDTH  write byte strobes
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready
rsp_rdata  output  DATA_WIDTH  read data (0 for writes)
rsp_err  output  1  pslverr or timeout
rsp_timeout  output  1  transfer aborted by timeout
paddr  output  ADDR_WIDTH  APB address
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
pwdata  output  DATA_WIDTH  APB write data
pstrb  output  STRB_WIDTH  APB strobes
prdata  input  DATA_WIDTH  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error

Behaviour:
- Clock is pclk. Reset is preset: synchronous, active-high. All APB and response outputs are registered.
- Reset values: state=IDLE. psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout = 0. paddr, pwdata, pstrb, rsp_rdata = 0.
- cmd_ready = (state==IDLE) && !preset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on cmd_valid&&cmd_ready, register cmd_addr→paddr, cmd_write→pwrite, cmd_wdata→pwdata. pstrb gets cmd_strb for writes, 0 for reads. Set psel=1, penable=0; go to SETUP.
- SETUP: lasts exactly one cycle. Set penable=1; go to ACCESS. paddr, pwrite, pwdata and pstrb stay unchanged from SETUP through ACCESS.
- ACCESS: completes on a clock edge where pready=1.
  - Capture rsp_rdata = pwrite ? 0 : prdata, and rsp_err = pslverr.
  - Next cycle: psel=0, penable=0, rsp_valid=1; go to RESP.
  - While pready=0, hold all APB outputs.
- RESP: hold rsp_valid and response data until rsp_ready. On the handshake, clear rsp_valid and go to IDLE.
- No command is accepted in SETUP/ACCESS/RESP.
- psel never stays high across two transfers; every transfer has a fresh SETUP.
- penable is never high without psel.
- Latency with pready=1 in the first ACCESS cycle:
  - command accepted at edge N
  - psel high after N; penable high after N+1
  - completion at edge N+2; rsp_valid high after N+2
  - if rsp_ready is high, back in IDLE after N+3
  - minimum 4 cycles per command
- pslverr is sampled only in the completing ACCESS cycle. pslverr in other cycles is ignored.
- Reset asserted in any state: next edge forces IDLE and all reset values. The in-flight command and any pending response are discarded; psel/penable drop in the same edge.
- cmd_* inputs are ignored when cmd_ready=0.

Optional Feature:
- Macro APB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with pready=0.
  - When the counter reaches TIMEOUT_CYCLES with pready still 0, the transfer aborts: next cycle psel=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata = all ones (0xFFFFFFFF).
  - pready=1 in the same cycle the limit is hit wins: normal completion, no timeout.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout is tied 0.

Test Plan:
- Write addr 0x04, data 0xDEADBEEF, strb 0xF, pready=1 → psel=1/penable=0 for one cycle, then psel=1/penable=1 with paddr=0x04 and pwdata=0xDEADBEEF stable; rsp_valid with rsp_err=0, rsp_rdata=0.
- Read addr 0x04, prdata=0x12345678 in ACCESS → pstrb=0, pwrite=0; rsp_rdata=0x12345678, rsp_err=0.
- Read addr 0xFF with slave returning pslverr=1, prdata=0xFFFFFFFF → rsp_err=1, rsp_rdata=0xFFFFFFFF, rsp_timeout=0.
- pready low for 3 ACCESS cycles, then high → APB outputs constant for all 4 ACCESS cycles; rsp_valid asserts exactly one cycle after pready=1.
- rsp_ready held low 5 cycles → rsp_valid and data stable, cmd_ready=0, psel=0 throughout; IDLE one cycle after rsp_ready=1.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready stuck 0 → abort after 16 wait cycles with rsp_err=1, rsp_timeout=1, rsp_rdata=0xFFFFFFFF. Separately, preset pulsed mid-ACCESS → psel=penable=rsp_valid=0 next cycle, cmd_ready=1 once preset is low.
